// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults and overlap-mode constants for seq_detect_gen.
package seq_det_pkg;
   localparam int   PAT_W_DEF = 4;
   localparam int   CNT_W_DEF = 8;
   localparam logic OVL_OFF   = 1'b0;
   localparam logic OVL_ON    = 1'b1;
endpackage

// File: rtl/seq_det_prefix_match.sv
// seq_det_prefix_match: next match depth = longest pattern prefix equal to the
// newest consumed bits, limited to bits seen since the last restart point.
module seq_det_prefix_match #(
   parameter int PAT_W = 4,
   localparam int K_W = $clog2(PAT_W + 1)
) (
   input  logic [PAT_W-1:0] hist_i,
   input  logic [K_W-1:0]   len_i,
   input  logic [PAT_W-1:0] pattern_i,
   input  logic             din_i,
   output logic [K_W-1:0]   k_o
);
   logic [PAT_W-1:0] h;
   logic [K_W-1:0]   l;
   logic             unused_msb;
   assign unused_msb = hist_i[PAT_W-1];
   always_comb begin
      h = {hist_i[PAT_W-2:0], din_i};
      l = (len_i == K_W'(PAT_W)) ? len_i : len_i + 1'b1;
      k_o = '0;
      for (int j = 1; j <= PAT_W; j++)
         if (K_W'(j) <= l && ((h ^ (pattern_i >> (PAT_W - j))) & ~({PAT_W{1'b1}} << j)) == '0)
            k_o = K_W'(j);
   end
endmodule

// File: rtl/seq_detect_gen.sv
// seq_detect_gen: configurable serial pattern detector with Moore detect flag.
// Define SEQ_DET_CNT_EN to add the saturating match_cnt output.
module seq_detect_gen
   import seq_det_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] pattern,
   input  logic             overlap_en,
   output logic             dout
`ifdef SEQ_DET_CNT_EN
   ,
   output logic [CNT_W-1:0] match_cnt
`endif
);
   localparam int K_W = $clog2(PAT_W + 1);
   logic [K_W-1:0]   k_q, k_d, k_nxt, len_q, len_d;
   logic [PAT_W-1:0] hist_q, hist_d, pat_q, pat_d;
   logic             ovl_q, ovl_d;
   seq_det_prefix_match #(.PAT_W(PAT_W)) u_prefix (
      .hist_i   (hist_q),
      .len_i    (len_q),
      .pattern_i(pat_q),
      .din_i    (din),
      .k_o      (k_nxt)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_q    <= '0;
         len_q  <= '0;
         hist_q <= '0;
         pat_q  <= '0;
         ovl_q  <= OVL_OFF;
      end else begin
         k_q    <= k_d;
         len_q  <= len_d;
         hist_q <= hist_d;
         pat_q  <= pat_d;
         ovl_q  <= ovl_d;
      end
   end
   // Without overlap, a completed match becomes the new restart point.
   always_comb begin
      k_d    = k_q;
      len_d  = len_q;
      hist_d = hist_q;
      pat_d  = pat_q;
      ovl_d  = ovl_q;
      if (cfg_load) begin
         k_d    = '0;
         len_d  = '0;
         hist_d = '0;
         pat_d  = pattern;
         ovl_d  = overlap_en;
      end else if (din_valid) begin
         k_d    = k_nxt;
         hist_d = {hist_q[PAT_W-2:0], din};
         len_d  = (k_nxt == K_W'(PAT_W) && ovl_q != OVL_ON) ? '0 :
                  (len_q == K_W'(PAT_W)) ? len_q : len_q + 1'b1;
      end
   end
   always_comb dout = (k_q == K_W'(PAT_W));
`ifdef SEQ_DET_CNT_EN
   logic             hit;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign hit = din_valid && !cfg_load && k_nxt == K_W'(PAT_W);
   always_comb cnt_d = cfg_load ? '0 : (hit && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
   assign match_cnt = cnt_q;
`else
   localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_seq_detect_gen.sv
// tb_seq_detect_gen: directed bench for seq_detect_gen (PAT_W=4, CNT_W=2).
// Counter checks are active when SEQ_DET_CNT_EN is defined.
module tb_seq_detect_gen;
   logic       clk = 1'b0, rst = 1'b0, din = 1'b0, din_valid = 1'b0, cfg_load = 1'b0;
   logic       overlap_en = 1'b0, dout;
   logic [3:0] pattern = 4'b0000;
   logic [1:0] match_cnt;
   int         n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   seq_detect_gen #(.PAT_W(4), .CNT_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .cfg_load  (cfg_load),
      .pattern   (pattern),
      .overlap_en(overlap_en),
      .dout      (dout)
`ifdef SEQ_DET_CNT_EN
      ,
      .match_cnt (match_cnt)
`endif
   );
`ifndef SEQ_DET_CNT_EN
   assign match_cnt = '0;
`endif

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cnt_chk(input string tag, input int e);
`ifdef SEQ_DET_CNT_EN
      chk(tag, {14'd0, match_cnt}, e[15:0]);
`endif
   endtask

   task automatic send(input logic b, input logic v, input logic e, input string tag);
      @(negedge clk);
      din = b;
      din_valid = v;
      @(posedge clk);
      #1;
      chk(tag, {15'd0, dout}, {15'd0, e});
   endtask

   task automatic stream(input logic [15:0] bits, input int n, input logic [15:0] e, input string tag);
      for (int i = n - 1; i >= 0; i--)
         send(bits[i], 1'b1, e[i], $sformatf("%s[%0d]", tag, n - 1 - i));
   endtask

   // Loads with din_valid high to show cfg_load wins, then scrambles the bus.
   task automatic cfg(input logic [3:0] p, input logic o, input string tag);
      @(negedge clk);
      pattern = p;
      overlap_en = o;
      cfg_load = 1'b1;
      din = 1'b1;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
      din_valid = 1'b0;
      pattern = ~p;
      overlap_en = ~o;
      chk({tag, "_dout"}, {15'd0, dout}, 16'd0);
      cnt_chk({tag, "_cnt"}, 0);
   endtask

   task automatic reset_pulse(input string tag);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk({tag, "_dout"}, {15'd0, dout}, 16'd0);
      cnt_chk({tag, "_cnt"}, 0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #3;
      chk("rst_dout", {15'd0, dout}, 16'd0);
      cnt_chk("rst_cnt", 0);
      @(negedge clk);
      rst = 1'b1;
      pattern = 4'b1101;
      overlap_en = 1'b1;
      stream(16'b1101, 4, 16'b0000, "nocfg");

      cfg(4'b1101, 1'b1, "cfg_ovl");
      stream(16'b1101101, 7, 16'b0001001, "ovl");
      cnt_chk("ovl_cnt", 2);

      cfg(4'b1101, 1'b0, "cfg_novl");
      stream(16'b1101101, 7, 16'b0001000, "novl");
      cnt_chk("novl_cnt", 1);

      cfg(4'b1101, 1'b1, "cfg_gap");
      stream(16'b11, 2, 16'b00, "gap_pre");
      for (int i = 0; i < 5; i++) send(1'b0, 1'b0, 1'b0, "gap_hold");
      stream(16'b01, 2, 16'b01, "gap_post");
      send(1'b0, 1'b0, 1'b1, "match_hold0");
      send(1'b1, 1'b0, 1'b1, "match_hold1");
      send(1'b1, 1'b1, 1'b0, "match_leave");
      cnt_chk("gap_cnt", 1);

      cfg(4'b1101, 1'b1, "cfg_rst");
      stream(16'b110, 3, 16'b000, "rst_pre");
      reset_pulse("rst_mid");
      send(1'b1, 1'b1, 1'b0, "rst_post");
      cfg(4'b1101, 1'b1, "cfg_rst2");
      stream(16'b1101, 4, 16'b0001, "rst_redo");
      cnt_chk("rst_redo_cnt", 1);
      reset_pulse("rst_match");
      stream(16'b00000, 5, 16'b00010, "rst_zero_pat");
      cnt_chk("rst_zero_cnt", 1);

      cfg(4'b0000, 1'b1, "cfg_zero");
      stream(16'b000000, 6, 16'b000111, "zeros");
      cnt_chk("zeros_cnt", 3);
      stream(16'b001, 3, 16'b110, "zeros_sat");
      cnt_chk("sat_cnt", 3);

      cfg(4'b1101, 1'b1, "cfg_old");
      stream(16'b110, 3, 16'b000, "old_pre");
      cfg(4'b1011, 1'b1, "cfg_new");
      stream(16'b1011, 4, 16'b0001, "new_pat");
      cnt_chk("new_cnt", 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/seq_detect_gen.md
SEQ_DETECT_GEN -- requirements
Module: seq_detect_gen

Interface
REQ-001 The module SHALL have parameter PAT_W, default 4, giving the pattern length in bits; legal range 2..16.
REQ-002 The module SHALL have parameter CNT_W, default 8, giving the match-counter width in bits.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port din, input, 1 bit: serial data bit.
REQ-006 Port din_valid, input, 1 bit: din is consumed on a rising edge only when this is 1.
REQ-007 Port cfg_load, input, 1 bit: one-cycle strobe that latches pattern and overlap_en and restarts detection.
REQ-008 Port pattern, input, PAT_W bits: target sequence, MSB is the first bit received.
REQ-009 Port overlap_en, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-010 Port dout, output, 1 bit: Moore detect flag, registered.
REQ-011 Port match_cnt, output, CNT_W bits: saturating count of detections (present only with SEQ_DET_CNT_EN).

Function
REQ-012 State SHALL be match depth k in 0..PAT_W: the number of leading pattern bits matched by the most recent valid bits; k = PAT_W is the MATCH state.
REQ-013 dout SHALL equal (k == PAT_W) and be a decode of registered state only, never of din.
REQ-014 dout SHALL assert in the cycle after the edge that consumes the final pattern bit; latency 1 clock.
REQ-015 On a consumed bit, next k SHALL be the longest j <= PAT_W such that pattern[PAT_W-1 -: j] equals the last j consumed bits since the last restart point.
REQ-016 With overlap_en=1, bits of a completed match SHALL remain eligible as a prefix of the next match.
REQ-017 With overlap_en=0, entering MATCH SHALL set the restart point, so the next k is computed from post-match bits only (leaving MATCH: k = 1 if din == pattern[PAT_W-1], else 0).
REQ-018 When din_valid=0, k, history and dout SHALL hold; MATCH therefore persists until the next consumed bit.
REQ-019 The block SHALL hold a PAT_W-bit history of consumed bits plus a valid-length count, so the REQ-015 search never uses pre-restart bits.
REQ-020 cfg_load SHALL latch pattern/overlap_en into internal registers, set k=0, clear history, and ignore din that cycle; it has priority over din_valid.
REQ-021 Changes on pattern/overlap_en without cfg_load SHALL have no effect.
REQ-022 An all-zero or all-one pattern SHALL be legal; in overlap mode, a run of identical matching bits yields dout=1 on every consumed bit after the first PAT_W.

Reset
REQ-023 rst=0 SHALL asynchronously force k=0, history cleared, dout=0, match_cnt=0, latched pattern=0, latched overlap_en=0.
REQ-024 Reset mid-sequence SHALL discard any partial match; after deassertion a full PAT_W bits are required before dout can assert.

Configuration
REQ-025 Macro SEQ_DET_CNT_EN defined: match_cnt port exists; it increments by 1 on each edge entering MATCH, saturates at 2^CNT_W-1, and clears on cfg_load or reset.
REQ-026 Macro SEQ_DET_CNT_EN undefined: match_cnt port and counter logic are absent; all other behaviour is identical.

Structure
REQ-027 A shared package seq_det_pkg SHALL hold the PAT_W/CNT_W defaults and the overlap-mode constants (OVL_OFF=0, OVL_ON=1).
REQ-028 The REQ-015 prefix search SHALL live in one sub-module, seq_det_prefix_match: combinational, PAT_W-parameterised, inputs history/valid-length/pattern/din, output next k.
REQ-029 The top level SHALL hold all registers: k, history, latched config and counter.

Verification
REQ-030 PAT_W=4, pattern 1101, overlap=1, stream 1101101 with valid every cycle -> dout high after bits 4 and 7; match_cnt=2.
REQ-031 Same stream, overlap=0 -> dout high after bit 4 only; match_cnt=1.
REQ-032 Pattern 1101, stream 11 then din_valid=0 for 5 cycles then 01 -> dout high after the final bit; k holds during the gap.
REQ-033 Pattern 1101, stream 110 then rst low for 1 cycle then 1 -> no detection; next 1101 -> detection.
REQ-034 Pattern 0000, overlap=1, 6 zeros -> dout=1 after bits 4, 5 and 6; CNT_W=2 with 5 matches -> match_cnt saturates at 3.
REQ-035 cfg_load with new pattern 1011 mid-stream after 110 -> partial match discarded; next 1011 detected, old 1101 not detected.
